ahb5_rst_seq_ctrl: RTL
======================

Name: ahb5_rst_seq_ctrl

Overview:
Parametrised reset sequencer and run-length watchdog for the AHB5 environment. It replaces the fixed clock/reset/`#500 $finish` scheme in the top level. It takes one master clock and one master reset and produces NUM_CH staggered, synchronously released per-channel resets (master, slaves, monitors). It also provides a programmable cycle-count watchdog that flags end-of-run. It sits between the top-level clock/reset source and every AHB5 agent.

Parameters:
NUM_CH, 4, number of independent reset output channels
REL_GAP, 8, clock cycles between successive channel releases (>=1)
SYNC_STAGES, 2, depth of the reset-deassertion synchroniser (>=2)
TIMEOUT_W, 16, width of the watchdog counter and limit register
DEFAULT_TIMEOUT, 50, watchdog limit loaded on reset (0 = watchdog disabled)

Ports:
Hclk  in  1  system clock, rising edge
HResetn  in  1  master reset; asynchronous assert, active-low
soft_rst_req  in  1  request a full re-sequence (single-cycle pulse)
ch_mask  in  NUM_CH  1 = channel held in reset permanently
timeout_load  in  1  load timeout_val into the limit register
timeout_val  in  TIMEOUT_W  new watchdog limit
rst_out_n  out  NUM_CH  per-channel active-low reset
all_released  out  1  every unmasked channel released
cycle_cnt  out  TIMEOUT_W  cycles elapsed in RUN
sim_done  out  1  sticky watchdog-expired flag

Behaviour:
- Clock and reset: single clock Hclk; reset HResetn is asynchronous and active-low.
- While HResetn=0, immediately and asynchronously:
  - rst_out_n=0, all_released=0, cycle_cnt=0, sim_done=0
  - synchroniser flops=0, limit=DEFAULT_TIMEOUT, state=ASSERT
- Deassertion is synchronised: a 1 shifts through SYNC_STAGES flops. ASSERT->HOLD on the edge after the synchroniser output goes 1.
- HOLD:
  - ch_mask is latched on entry and held until the next entry.
  - Gap counter counts REL_GAP cycles, then -> RELEASE with idx=0.
- RELEASE:
  - Walks idx 0..NUM_CH-1.
  - Masked channels are skipped with zero cycles consumed.
  - Each unmasked channel's rst_out_n bit rises REL_GAP cycles after the previous release (or after HOLD exit for the first).
  - all_released rises on the same edge as the last unmasked release, then -> RUN.
  - All channels masked: HOLD -> RUN directly; all_released=1, all rst_out_n=0.
- RUN:
  - cycle_cnt increments by 1 each cycle, saturating at all-ones.
  - When limit!=0 and cycle_cnt+1==limit: cycle_cnt=limit, sim_done=1, -> DONE.
- DONE: cycle_cnt holds; sim_done stays 1 until HResetn or soft reset.
- soft_rst_req in HOLD/RELEASE/RUN/DONE, on the next edge:
  - all rst_out_n=0, all_released=0, cycle_cnt=0, sim_done=0
  - -> HOLD, gap counter cleared
  - Limit register is untouched.
  - Ignored in ASSERT.
- timeout_load is accepted in any state except ASSERT and updates the limit on the next edge.
- Same-cycle rules:
  - soft_rst_req beats watchdog expiry.
  - The expiry compare uses the pre-load limit value.
- HResetn low mid-sequence returns to the reset values immediately, regardless of state.
- State encoding is internal; no other state is reachable.

Optional Feature:
Macro AHB5_RST_SEQ_SOFT_FILTER_EN.
- Defined: soft_rst_req is accepted only after it has been sampled high on 2 consecutive edges. The re-sequence starts on the edge after the second sample. A 1-cycle pulse is ignored; a level held high triggers exactly once until it drops.
- Undefined: a single-cycle sample is accepted, as described above.

Test Plan:
Defaults, HResetn low 3 cycles then high before edge 1 -> HOLD at edge 3; rst_out_n[0..3] rise at edges 11/19/27/35; all_released=1 at edge 35.
ch_mask=4'b0101 at deassertion -> bits 1,3 rise at edges 11/19; bits 0,2 stay 0; all_released=1 at edge 19.
Default limit 50 -> sim_done=1 and cycle_cnt=50 exactly 50 cycles after all_released; both hold for 20 further cycles.
In RUN at cycle_cnt=10, timeout_load with timeout_val=0 -> cycle_cnt counts past 50, sim_done never rises; 16-bit saturation holds at 16'hFFFF.
soft_rst_req pulse on the same cycle the watchdog would expire -> sim_done stays 0; all rst_out_n=0 next edge; releases repeat at +8/+16/+24/+32.
HResetn dropped during RELEASE after ch0 is out -> rst_out_n=0 asynchronously (before the next edge); re-release follows the first-scenario timing. With the macro defined, a 1-cycle soft_rst_req causes no change.

Source files
------------

// File: rtl/ahb5_rst_seq_ctrl.sv
// ahb5_rst_seq_ctrl: staggered per-channel reset release and run-length
// watchdog for the AHB5 environment.
// Optional build macro: AHB5_RST_SEQ_SOFT_FILTER_EN. When it is defined,
// soft_rst_req must be sampled high on two consecutive edges before it is
// honoured. A held level fires only once, until it drops.
//
// state   | meaning
// ASSERT  | waiting for synchronised HResetn deassertion
// HOLD    | mask latched, counting the first release gap
// RELEASE | releasing unmasked channels one gap apart
// RUN     | every unmasked channel released, watchdog counting
// DONE    | watchdog expired, sim_done sticky
module ahb5_rst_seq_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int REL_GAP         = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_W       = 16,
  parameter int DEFAULT_TIMEOUT = 50
) (
  input  logic                 Hclk,
  input  logic                 HResetn,
  input  logic                 soft_rst_req,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 timeout_load,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  output logic [NUM_CH-1:0]    rst_out_n,
  output logic                 all_released,
  output logic [TIMEOUT_W-1:0] cycle_cnt,
  output logic                 sim_done
);

  localparam int                   GAP_W     = $clog2(REL_GAP) + 1;
  localparam logic [GAP_W-1:0]     GAP_TC    = GAP_W'(REL_GAP - 1);
  localparam logic [TIMEOUT_W-1:0] LIMIT_RST = TIMEOUT_W'(DEFAULT_TIMEOUT);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic [NUM_CH-1:0]      rel_q, rel_d;
  logic                   all_rel_q, all_rel_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   limit_q, limit_d;
  logic                   done_q, done_d;

  logic                   soft_go;
  logic [NUM_CH-1:0]      pend, pend_low;
  logic                   pend_last;
  logic [TIMEOUT_W:0]     cnt_inc;
  logic                   expire;

`ifdef AHB5_RST_SEQ_SOFT_FILTER_EN
  logic soft_smp_q, soft_smp_d;
  logic soft_acc_q, soft_acc_d;
  logic soft_fired_q, soft_fired_d;

  // Two-sample qualifier: accept once per high level, act on the following edge
  always_comb begin
    soft_smp_d   = soft_rst_req;
    soft_acc_d   = soft_rst_req & soft_smp_q & ~soft_fired_q;
    soft_fired_d = soft_rst_req & (soft_fired_q | soft_acc_d);
  end

  // Soft-request qualifier registers
  always_ff @(posedge Hclk or negedge HResetn) begin
    if (!HResetn) begin
      soft_smp_q   <= 1'b0;
      soft_acc_q   <= 1'b0;
      soft_fired_q <= 1'b0;
    end else begin
      soft_smp_q   <= soft_smp_d;
      soft_acc_q   <= soft_acc_d;
      soft_fired_q <= soft_fired_d;
    end
  end

  assign soft_go = soft_acc_q & (state_q != ST_ASSERT);
`else
  assign soft_go = soft_rst_req & (state_q != ST_ASSERT);
`endif

  // Next channel to release is the lowest unmasked channel still held in reset
  always_comb begin
    pend      = ~mask_q & ~rel_q;
    pend_low  = pend & (~pend + NUM_CH'(1));
    pend_last = ((pend & ~pend_low) == '0);
    cnt_inc   = {1'b0, cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    expire    = (limit_q != '0) && (cnt_inc == {1'b0, limit_q});
  end

  // Next-state and output logic; a soft request overrides everything except the limit
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    gap_d     = gap_q;
    mask_d    = mask_q;
    rel_d     = rel_q;
    all_rel_d = all_rel_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    done_d    = done_q;

    if (timeout_load && (state_q != ST_ASSERT)) begin
      limit_d = timeout_val;
    end

    case (state_q)
      ST_ASSERT: begin
        if (sync_q[SYNC_STAGES-1]) begin
          state_d = ST_HOLD;
          mask_d  = ch_mask;
          gap_d   = '0;
        end
      end
      ST_HOLD, ST_RELEASE: begin
        if (gap_q == GAP_TC) begin
          gap_d = '0;
          if (pend == '0) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            rel_d = rel_q | pend_low;
            if (pend_last) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_inc[TIMEOUT_W-1:0];
        end
        if (expire) begin
          cnt_d   = limit_q;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    if (soft_go) begin
      state_d   = ST_HOLD;
      mask_d    = ch_mask;
      gap_d     = '0;
      rel_d     = '0;
      all_rel_d = 1'b0;
      cnt_d     = '0;
      done_d    = 1'b0;
    end
  end

  // State and datapath registers, all cleared asynchronously by HResetn
  always_ff @(posedge Hclk or negedge HResetn) begin
    if (!HResetn) begin
      state_q   <= ST_ASSERT;
      sync_q    <= '0;
      gap_q     <= '0;
      mask_q    <= '0;
      rel_q     <= '0;
      all_rel_q <= 1'b0;
      cnt_q     <= '0;
      limit_q   <= LIMIT_RST;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      gap_q     <= gap_d;
      mask_q    <= mask_d;
      rel_q     <= rel_d;
      all_rel_q <= all_rel_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      done_q    <= done_d;
    end
  end

  assign rst_out_n    = rel_q;
  assign all_released = all_rel_q;
  assign cycle_cnt    = cnt_q;
  assign sim_done     = done_q;

endmodule
